// File: rtl/count_sched_if.sv
// Bus bundle for the round-robin counter scheduler.
// The requester side (master) drives req/dir/len and watches the grant,
// counter and status outputs; the scheduler (slave) does the reverse.
interface count_sched_if #(
  parameter int N_CH = 4,
  parameter int CW   = 3,
  parameter int LW   = 4
);
  logic [N_CH-1:0]    req;
  logic [N_CH-1:0]    dir;
  logic [N_CH*LW-1:0] len;
  logic [N_CH-1:0]    gnt;
  logic [CW-1:0]      cnt;
  logic               busy;
  logic [N_CH-1:0]    done;
  logic               wrap;

  modport master (
    output req, dir, len,
    input  gnt, cnt, busy, done, wrap
  );

  modport slave (
    input  req, dir, len,
    output gnt, cnt, busy, done, wrap
  );
endinterface

// File: rtl/count_sched.sv
// Round-robin scheduler that time-slices one CW-bit up/down counter among
// N_CH requesters. A granted channel gets the counter loaded with its start
// value (0 when counting up, all-ones when counting down), the counter steps
// once per cycle for the channel's requested length, then a one-cycle done
// pulse is issued and priority rotates past the channel that just ran.
// Every output comes straight from a register.
module count_sched #(
  parameter int N_CH = 4,
  parameter int CW   = 3,
  parameter int LW   = 4
) (
  input  logic         clk,
  input  logic         rst,
  count_sched_if.slave bus
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [CW-1:0]   CNT_MAX = '1;
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [LW-1:0]   REM_ONE = LW'(1);
  localparam logic [N_CH-1:0] OH_ONE  = N_CH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Registered outputs and their next values
  logic [N_CH-1:0] gnt_r, gnt_nxt;
  logic [N_CH-1:0] done_r, done_nxt;
  logic [CW-1:0]   cnt_r, cnt_nxt;
  logic            busy_r, busy_nxt;
  logic            wrap_r, wrap_nxt;

  // Internal run context: direction, remaining steps, owner, rotation pointer
  logic            dir_r, dir_nxt;
  logic [LW-1:0]   rem_r, rem_nxt;
  logic [PW-1:0]   cur_r, cur_nxt;
  logic [PW-1:0]   ptr_r, ptr_nxt;

  // Arbitration result and per-step helpers
  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic [LW-1:0]   pick_len;
  logic            pick_dir;
  logic [CW-1:0]   cnt_step;
  logic            step_wraps;
  logic            owner_req;

  // Channel index base+off, wrapped modulo N_CH (off is always < N_CH)
  function automatic logic [PW-1:0] ring_add(input logic [PW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_CH) sum = sum - N_CH;
    return sum[PW-1:0];
  endfunction

  // Round-robin scan starting at ptr: the first active request wins
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_r;
    for (int i = 0; i < N_CH; i++) begin
      if (!pick_found && bus.req[ring_add(ptr_r, i)]) begin
        pick_found = 1'b1;
        pick_idx   = ring_add(ptr_r, i);
      end
    end
  end

  assign pick_len = bus.len[int'(pick_idx)*LW +: LW];
  assign pick_dir = bus.dir[pick_idx];

  // The counter step for the latched direction, and whether it crosses the end
  assign cnt_step   = dir_r ? (cnt_r + CNT_ONE) : (cnt_r - CNT_ONE);
  assign step_wraps = dir_r ? (cnt_r == CNT_MAX) : (cnt_r == '0);

  // The owning channel must keep its request up, otherwise the run is aborted
  assign owner_req  = bus.req[cur_r];

  // Next-state and next-output logic; everything defaults to holding,
  // while done and wrap default low so they only ever pulse for one cycle
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_r;
    cnt_nxt   = cnt_r;
    busy_nxt  = busy_r;
    done_nxt  = '0;
    wrap_nxt  = 1'b0;
    dir_nxt   = dir_r;
    rem_nxt   = rem_r;
    cur_nxt   = cur_r;
    ptr_nxt   = ptr_r;

    unique case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = RUN;
          gnt_nxt   = OH_ONE << pick_idx;
          busy_nxt  = 1'b1;
          cur_nxt   = pick_idx;
          dir_nxt   = pick_dir;
          rem_nxt   = (pick_len == '0) ? REM_ONE : pick_len;
          cnt_nxt   = pick_dir ? '0 : CNT_MAX;
        end
      end

      RUN: begin
        if (!owner_req) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
          ptr_nxt   = ring_add(cur_r, 1);
        end else begin
          cnt_nxt  = cnt_step;
          wrap_nxt = step_wraps;
          rem_nxt  = rem_r - REM_ONE;
          if (rem_r == REM_ONE) begin
            state_nxt = DONE;
            done_nxt  = gnt_r;
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
        ptr_nxt   = ring_add(cur_r, 1);
      end

      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wipes any run in progress silently
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt_r  <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
      done_r <= '0;
      wrap_r <= 1'b0;
      dir_r  <= 1'b0;
      rem_r  <= '0;
      cur_r  <= '0;
      ptr_r  <= '0;
    end else begin
      state  <= state_nxt;
      gnt_r  <= gnt_nxt;
      cnt_r  <= cnt_nxt;
      busy_r <= busy_nxt;
      done_r <= done_nxt;
      wrap_r <= wrap_nxt;
      dir_r  <= dir_nxt;
      rem_r  <= rem_nxt;
      cur_r  <= cur_nxt;
      ptr_r  <= ptr_nxt;
    end
  end

  assign bus.gnt  = gnt_r;
  assign bus.cnt  = cnt_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.wrap = wrap_r;

endmodule
